// File: rtl/wb_stage.sv
// Write-back stage: LS/WB pipeline register, write-back select, register-file write port.
// Optional retirement counters are built when WB_PERF_CNT_EN is defined.
module wb_stage #(
   localparam int unsigned XLEN     = 64,
   localparam int unsigned INST_LEN = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                valid_i,
   input  logic [XLEN-1:0]     pc_i,
   input  logic [INST_LEN-1:0] instr_i,
   input  logic [XLEN-1:0]     alures_i,
   input  logic [XLEN-1:0]     ls_res_i,
   input  logic                stall_i,
   input  logic                flush_i,
   output logic                rf_wen_o,
   output logic [4:0]          rf_waddr_o,
   output logic [XLEN-1:0]     rf_wdata_o,
   output logic                wb_valid_o,
   output logic [XLEN-1:0]     wb_pc_o,
   output logic [INST_LEN-1:0] wb_instr_o,
   output logic [XLEN-1:0]     wb_alures_o,
   output logic                ebreak_o,
   output logic [63:0]         retire_cnt_o,
   output logic [63:0]         load_cnt_o
);

   localparam logic [INST_LEN-1:0] NOP    = 32'h0000_0013;
   localparam logic [INST_LEN-1:0] EBREAK = 32'h0010_0073;

   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_IMM    = 5'b00100;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_IMM32  = 5'b00110;
   localparam logic [4:0] OP_OP     = 5'b01100;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_OP32   = 5'b01110;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;

   typedef struct packed {
      logic                valid;
      logic [XLEN-1:0]     pc;
      logic [INST_LEN-1:0] instr;
      logic [XLEN-1:0]     alures;
      logic [XLEN-1:0]     ldres;
   } lswb_t;

   lswb_t       wb_q;
   logic [4:0]  opc;
   logic        rd_write;
   logic        retire;

   // LS/WB register: flush beats stall; bubbles carry a NOP so they never decode as memory ops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_q.valid  <= 1'b0;
         wb_q.pc     <= '0;
         wb_q.instr  <= NOP;
         wb_q.alures <= '0;
         wb_q.ldres  <= '0;
      end else if (flush_i) begin
         wb_q.valid  <= 1'b0;
         wb_q.instr  <= NOP;
      end else if (!stall_i) begin
         wb_q.valid  <= valid_i;
         wb_q.pc     <= pc_i;
         wb_q.instr  <= valid_i ? instr_i : NOP;
         wb_q.alures <= alures_i;
         wb_q.ldres  <= ls_res_i;
      end
   end

   assign opc = wb_q.instr[6:2];

   // Write-back decode and data select
   always_comb begin
      rd_write   = 1'b0;
      rf_wdata_o = '0;
      unique case (opc)
         OP_LOAD, OP_IMM, OP_AUIPC, OP_IMM32, OP_OP,
         OP_LUI, OP_OP32, OP_JALR, OP_JAL: rd_write = 1'b1;
         default:                          rd_write = 1'b0;
      endcase
      if (wb_q.valid) begin
         if (opc == OP_LOAD)
            rf_wdata_o = wb_q.ldres;
         else if ((opc == OP_JAL) || (opc == OP_JALR))
            rf_wdata_o = wb_q.pc + XLEN'(4);
         else
            rf_wdata_o = wb_q.alures;
      end
   end

   assign rf_waddr_o  = wb_q.instr[11:7];
   assign rf_wen_o    = wb_q.valid & rd_write & (wb_q.instr[11:7] != 5'd0);
   assign wb_valid_o  = wb_q.valid;
   assign wb_pc_o     = wb_q.pc;
   assign wb_instr_o  = wb_q.instr;
   assign wb_alures_o = wb_q.alures;

   // An entry retires on the edge where it leaves WB; a flush does not stop it leaving
   assign retire   = wb_q.valid & (~stall_i | flush_i);
   assign ebreak_o = retire & (wb_q.instr == EBREAK);

`ifdef WB_PERF_CNT_EN
   logic [63:0] retire_cnt_q;
   logic [63:0] load_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_cnt_q <= '0;
         load_cnt_q   <= '0;
      end else if (retire) begin
         retire_cnt_q <= retire_cnt_q + 64'(1);
         if (opc == OP_LOAD)
            load_cnt_q <= load_cnt_q + 64'(1);
      end
   end

   assign retire_cnt_o = retire_cnt_q;
   assign load_cnt_o   = load_cnt_q;
`else
   assign retire_cnt_o = 64'b0;
   assign load_cnt_o   = 64'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed vectors with hand-computed expectations.
// Counter expectations collapse to zero unless WB_PERF_CNT_EN is defined.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_i = 1'b0;
   logic [63:0] pc_i = '0;
   logic [31:0] instr_i = '0;
   logic [63:0] alures_i = '0;
   logic [63:0] ls_res_i = '0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        rf_wen_o;
   logic [4:0]  rf_waddr_o;
   logic [63:0] rf_wdata_o;
   logic        wb_valid_o;
   logic [63:0] wb_pc_o;
   logic [31:0] wb_instr_o;
   logic [63:0] wb_alures_o;
   logic        ebreak_o;
   logic [63:0] retire_cnt_o;
   logic [63:0] load_cnt_o;

   wb_stage dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
      .alures_i(alures_i), .ls_res_i(ls_res_i), .stall_i(stall_i), .flush_i(flush_i),
      .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .wb_valid_o(wb_valid_o), .wb_pc_o(wb_pc_o), .wb_instr_o(wb_instr_o),
      .wb_alures_o(wb_alures_o), .ebreak_o(ebreak_o),
      .retire_cnt_o(retire_cnt_o), .load_cnt_o(load_cnt_o)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ADDI1  = 32'h0050_0093;  // addi x1,x0,5
   localparam logic [31:0] LD2    = 32'h0000_B103;  // ld x2,0(x1)
   localparam logic [31:0] LW3    = 32'h0000_A183;  // lw x3,0(x1)
   localparam logic [31:0] JAL1   = 32'h0000_00EF;  // jal x1,0
   localparam logic [31:0] SD     = 32'h0020_B423;  // sd x2,8(x1)
   localparam logic [31:0] BEQ    = 32'h0020_8863;  // beq x1,x2,16
   localparam logic [31:0] ADDIX0 = 32'h0010_0013;  // addi x0,x0,1
   localparam logic [31:0] LUI5   = 32'h1234_52B7;  // lui x5,0x12345
   localparam logic [31:0] EBRK   = 32'h0010_0073;

   typedef struct {
      logic        wbv;
      logic [31:0] instr;
      logic [63:0] pc;
      logic [63:0] alu;
      logic        wen;
      logic [4:0]  waddr;
      logic [63:0] wdata;
      logic        eb;
      logic [63:0] rc;
      logic [63:0] lc;
      int          id;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   step_id = 0;

   task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL step%0d %s: got %h expected %h", id, name, act, req);
      end
   endtask

   // Drive one vector at a negedge and queue what the outputs must show before the next edge
   task automatic step(input logic rst, input logic v, input logic st, input logic fl,
                       input logic [63:0] pc, input logic [31:0] ins, input logic [63:0] alu,
                       input logic [63:0] ls,
                       input logic e_wbv, input logic [31:0] e_ins, input logic [63:0] e_pc,
                       input logic [63:0] e_alu, input logic e_wen, input logic [4:0] e_wa,
                       input logic [63:0] e_wd, input logic e_eb, input logic [63:0] e_rc,
                       input logic [63:0] e_lc);
      exp_t e;
      @(negedge clk);
      rst_n = rst; valid_i = v; stall_i = st; flush_i = fl;
      pc_i = pc; instr_i = ins; alures_i = alu; ls_res_i = ls;
      e.wbv = e_wbv; e.instr = e_ins; e.pc = e_pc; e.alu = e_alu; e.wen = e_wen;
      e.waddr = e_wa; e.wdata = e_wd; e.eb = e_eb;
`ifdef WB_PERF_CNT_EN
      e.rc = e_rc; e.lc = e_lc;
`else
      e.rc = 64'd0; e.lc = 64'd0;
`endif
      e.id = step_id;
      step_id++;
      exp_q.push_back(e);
   endtask

   task automatic rand_reset_step();
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom}, $urandom,
           {$urandom, $urandom}, {$urandom, $urandom},
           1'b0, NOP, 64'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0);
   endtask

   // Monitor: sample mid-cycle before the rising edge and compare against the queue head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_valid", e.id, 64'(wb_valid_o), 64'(e.wbv));
            chk("wb_instr", e.id, 64'(wb_instr_o), 64'(e.instr));
            chk("wb_pc", e.id, wb_pc_o, e.pc);
            chk("wb_alures", e.id, wb_alures_o, e.alu);
            chk("rf_wen", e.id, 64'(rf_wen_o), 64'(e.wen));
            chk("rf_waddr", e.id, 64'(rf_waddr_o), 64'(e.waddr));
            chk("rf_wdata", e.id, rf_wdata_o, e.wdata);
            chk("ebreak", e.id, 64'(ebreak_o), 64'(e.eb));
            chk("retire_cnt", e.id, retire_cnt_o, e.rc);
            chk("load_cnt", e.id, load_cnt_o, e.lc);
         end
      end
   end

   initial begin
      // reset with random inputs
      rand_reset_step();
      rand_reset_step();
      //    rst v  st fl pc                instr   alu                 ls                   | wbv instr  pc                alu               wen wa     wdata                 eb rc      lc
      step(1, 1, 0, 0, 64'h1000,         ADDI1,  64'd5,              64'd0,               0, NOP,    64'h0,            64'h0,            0, 5'd0,  64'h0,                0, 64'd0,  64'd0);
      step(1, 1, 0, 0, 64'h1004,         LD2,    64'h8000_0000,      64'hDEADBEEF00000001, 1, ADDI1, 64'h1000,         64'd5,            1, 5'd1,  64'd5,                0, 64'd0,  64'd0);
      step(1, 1, 0, 0, 64'h8000_0010,    JAL1,   64'h55,             64'h77,              1, LD2,    64'h1004,         64'h8000_0000,    1, 5'd2,  64'hDEADBEEF00000001, 0, 64'd1,  64'd0);
      step(1, 1, 0, 0, 64'h2000,         SD,     64'h1234,           64'h9,               1, JAL1,   64'h8000_0010,    64'h55,           1, 5'd1,  64'h8000_0014,        0, 64'd2,  64'd1);
      step(1, 1, 0, 0, 64'h2004,         BEQ,    64'h0,              64'h0,               1, SD,     64'h2000,         64'h1234,         0, 5'd8,  64'h1234,             0, 64'd3,  64'd1);
      step(1, 1, 0, 0, 64'h2008,         ADDIX0, 64'h1,              64'h0,               1, BEQ,    64'h2004,         64'h0,            0, 5'd16, 64'h0,                0, 64'd4,  64'd1);
      step(1, 0, 0, 0, 64'h3000,         LW3,    64'h99,             64'h88,              1, ADDIX0, 64'h2008,         64'h1,            0, 5'd0,  64'h1,                0, 64'd5,  64'd1);
      step(1, 1, 0, 0, 64'h3004,         LW3,    64'h40,             64'hFFFFFFFFFFFFFF80, 0, NOP,   64'h3000,         64'h99,           0, 5'd0,  64'h0,                0, 64'd6,  64'd1);
      step(1, 1, 0, 0, 64'h3008,         ADDI1,  64'd5,              64'h0,               1, LW3,    64'h3004,         64'h40,           1, 5'd3,  64'hFFFFFFFFFFFFFF80, 0, 64'd6,  64'd1);
      step(1, 1, 0, 0, 64'h300C,         LUI5,   64'h1234_5000,      64'h0,               1, ADDI1,  64'h3008,         64'd5,            1, 5'd1,  64'd5,                0, 64'd7,  64'd2);
      // stall for three cycles: LUI entry held and counted once
      step(1, 1, 1, 0, 64'h4000,         ADDI1,  64'd7,              64'h0,               1, LUI5,   64'h300C,         64'h1234_5000,    1, 5'd5,  64'h1234_5000,        0, 64'd8,  64'd2);
      step(1, 1, 1, 0, 64'h4000,         ADDI1,  64'd7,              64'h0,               1, LUI5,   64'h300C,         64'h1234_5000,    1, 5'd5,  64'h1234_5000,        0, 64'd8,  64'd2);
      step(1, 1, 1, 0, 64'h4000,         ADDI1,  64'd7,              64'h0,               1, LUI5,   64'h300C,         64'h1234_5000,    1, 5'd5,  64'h1234_5000,        0, 64'd8,  64'd2);
      step(1, 1, 0, 0, 64'h4004,         LD2,    64'h10,             64'hAB,              1, LUI5,   64'h300C,         64'h1234_5000,    1, 5'd5,  64'h1234_5000,        0, 64'd8,  64'd2);
      // flush with stall: load in WB still retires, incoming addi is killed
      step(1, 1, 1, 1, 64'h5000,         ADDI1,  64'd3,              64'h0,               1, LD2,    64'h4004,         64'h10,           1, 5'd2,  64'hAB,               0, 64'd9,  64'd2);
      step(1, 1, 0, 0, 64'h5004,         EBRK,   64'h0,              64'h0,               0, NOP,    64'h4004,         64'h10,           0, 5'd0,  64'h0,                0, 64'd10, 64'd3);
      step(1, 1, 0, 0, 64'h5008,         NOP,    64'h0,              64'h0,               1, EBRK,   64'h5004,         64'h0,            0, 5'd0,  64'h0,                1, 64'd10, 64'd3);
      step(1, 1, 0, 0, 64'h6000,         EBRK,   64'h0,              64'h0,               1, NOP,    64'h5008,         64'h0,            0, 5'd0,  64'h0,                0, 64'd11, 64'd3);
      // stalled ebreak: no pulse until it leaves
      step(1, 1, 1, 0, 64'h7000,         NOP,    64'h0,              64'h0,               1, EBRK,   64'h6000,         64'h0,            0, 5'd0,  64'h0,                0, 64'd12, 64'd3);
      step(1, 0, 0, 0, 64'h7004,         NOP,    64'h0,              64'h0,               1, EBRK,   64'h6000,         64'h0,            0, 5'd0,  64'h0,                1, 64'd12, 64'd3);
      step(1, 1, 0, 0, 64'h8000,         ADDI1,  64'd5,              64'h0,               0, NOP,    64'h7004,         64'h0,            0, 5'd0,  64'h0,                0, 64'd13, 64'd3);
      // asynchronous reset mid-operation clears state before any edge
      step(0, 1, 0, 0, 64'h8000,         ADDI1,  64'd5,              64'h0,               0, NOP,    64'h0,            64'h0,            0, 5'd0,  64'h0,                0, 64'd0,  64'd0);
      step(1, 0, 0, 0, 64'h0,            NOP,    64'h0,              64'h0,               0, NOP,    64'h0,            64'h0,            0, 5'd0,  64'h0,                0, 64'd0,  64'd0);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", step_id, 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
